// File: rtl/dual_port_fifo_pkg.sv
// Shared definitions for dual_port_fifo: default parameters, depth helper and
// the packed stereo sample word carried between the audio producer and consumer.
package dual_port_fifo_pkg;

  localparam int DEFAULT_DATESIZE      = 32;
  localparam int DEFAULT_ADDRSIZE      = 4;
  localparam int DEFAULT_ALMOST_MARGIN = 2;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } audio_word_t;

  function automatic int fifo_depth(input int addrsize);
    return 32'sd1 <<< addrsize;
  endfunction

endpackage

// File: rtl/dual_port_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset so it maps
// onto distributed RAM.
module dual_port_fifo_mem
  import dual_port_fifo_pkg::*;
#(
  parameter int DATESIZE = DEFAULT_DATESIZE,
  parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATESIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATESIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);

  logic [DATESIZE-1:0] mem_r [0:DEPTH-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/dual_port_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/almost flags.
// Define DUAL_PORT_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module dual_port_fifo
  import dual_port_fifo_pkg::*;
#(
  parameter int DATESIZE      = DEFAULT_DATESIZE,
  parameter int ADDRSIZE      = DEFAULT_ADDRSIZE,
  parameter int ALMOST_MARGIN = DEFAULT_ALMOST_MARGIN
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                winc,
  input  logic [DATESIZE-1:0] wdata,
  output logic                wfull,
  input  logic                rinc,
  output logic [DATESIZE-1:0] rdata,
  output logic                rempty,
  output logic                almost_full,
`ifdef DUAL_PORT_FIFO_ERR_EN
  output logic                overflow,
  output logic                underflow,
`endif
  output logic                almost_empty
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] DEPTH_C     = PW'(fifo_depth(ADDRSIZE));
  localparam logic [ADDRSIZE:0] AF_THRESH_C = PW'(fifo_depth(ADDRSIZE) - ALMOST_MARGIN);
  localparam logic [ADDRSIZE:0] AE_THRESH_C = PW'(ALMOST_MARGIN);
  localparam logic [ADDRSIZE:0] PTR_ONE_C   = {{ADDRSIZE{1'b0}}, 1'b1};

  logic              we_s;
  logic              re_s;
  logic [ADDRSIZE:0] wptr_r;
  logic [ADDRSIZE:0] rptr_r;
  logic [ADDRSIZE:0] wptr_nxt_s;
  logic [ADDRSIZE:0] rptr_nxt_s;
  logic [ADDRSIZE:0] count_nxt_s;

  // Request gating and next-state pointers; flags are derived from the post-edge count
  always_comb begin
    we_s = winc & ~wfull;
    re_s = rinc & ~rempty;
    if (we_s) begin
      wptr_nxt_s = wptr_r + PTR_ONE_C;
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (re_s) begin
      rptr_nxt_s = rptr_r + PTR_ONE_C;
    end else begin
      rptr_nxt_s = rptr_r;
    end
    count_nxt_s = wptr_nxt_s - rptr_nxt_s;
  end

  // Pointer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
    end else begin
      wptr_r <= wptr_nxt_s;
      rptr_r <= rptr_nxt_s;
    end
  end

  // Registered status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rempty       <= 1'b1;
      wfull        <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      rempty       <= (count_nxt_s == {PW{1'b0}});
      wfull        <= (count_nxt_s == DEPTH_C);
      almost_empty <= (count_nxt_s <= AE_THRESH_C);
      almost_full  <= (count_nxt_s >= AF_THRESH_C);
    end
  end

`ifdef DUAL_PORT_FIFO_ERR_EN
  // Sticky error flags: a dropped request is recorded even if the other port proceeds
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (winc & wfull);
      underflow <= underflow | (rinc & rempty);
    end
  end
`endif

  dual_port_fifo_mem #(
    .DATESIZE (DATESIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (wptr_r[ADDRSIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_r[ADDRSIZE-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dual_port_fifo.sv
// Self-checking bench for dual_port_fifo: random and directed traffic against a
// queue-based reference model of the FIFO contents.
module tb_dual_port_fifo;
  import dual_port_fifo_pkg::*;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        winc;
  logic [31:0] wdata;
  logic        wfull;
  logic        rinc;
  logic [31:0] rdata;
  logic        rempty;
  logic        almost_full;
  logic        almost_empty;
`ifdef DUAL_PORT_FIFO_ERR_EN
  logic        overflow;
  logic        underflow;
`endif

  logic [31:0] model_q[$];
  bit          exp_ovf;
  bit          exp_unf;
  int          vectors     = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dual_port_fifo dut (
    .clk          (clk),
    .resetn       (resetn),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .rinc         (rinc),
    .rdata        (rdata),
    .rempty       (rempty),
    .almost_full  (almost_full),
`ifdef DUAL_PORT_FIFO_ERR_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .almost_empty (almost_empty)
  );

  // {rempty, wfull, almost_empty, almost_full} implied by the model occupancy
  function automatic logic [3:0] exp_flags();
    int n;
    n = model_q.size();
    return {n == 0, n == DEPTH, n <= MARGIN, n >= DEPTH - MARGIN};
  endfunction

  // One clock of stimulus; the model applies the gating rules to the pre-edge occupancy
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    bit full_b;
    bit empty_b;
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    full_b  = (model_q.size() == DEPTH);
    empty_b = (model_q.size() == 0);
    if (w && full_b)   exp_ovf = 1'b1;
    if (r && empty_b)  exp_unf = 1'b1;
    if (r && !empty_b) void'(model_q.pop_front());
    if (w && !full_b)  model_q.push_back(d);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  task automatic fill_to(input int n);
    while (model_q.size() < n) step(1'b1, 1'b0, $urandom);
  endtask

  task automatic drain_to(input int n);
    while (model_q.size() > n) step(1'b0, 1'b1, 32'd0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 32'd0;
    #12;
    vectors++;
    if ({rempty, wfull, almost_empty, almost_full} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 1010", {rempty, wfull, almost_empty, almost_full});
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd0);
      vectors++;
      if ({rempty, wfull, almost_empty, almost_full} !== 4'b1010) begin
        miscompares++;
        $display("FAIL idle_flags cycle %0d: got %b expected 1010", i, {rempty, wfull, almost_empty, almost_full});
      end
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 1'b0, 32'(k));
      vectors++;
      if ({rempty, wfull, almost_empty, almost_full} !== exp_flags()) begin
        miscompares++;
        $display("FAIL fill_flags write %0d: got %b expected %b", k, {rempty, wfull, almost_empty, almost_full}, exp_flags());
      end
    end
    for (int k = 1; k <= DEPTH; k++) begin
      vectors++;
      if (rdata !== 32'(k)) begin
        miscompares++;
        $display("FAIL drain_data read %0d: got %h expected %h", k, rdata, 32'(k));
      end
      step(1'b0, 1'b1, 32'd0);
      vectors++;
      if ({rempty, wfull, almost_empty, almost_full} !== exp_flags()) begin
        miscompares++;
        $display("FAIL drain_flags read %0d: got %b expected %b", k, {rempty, wfull, almost_empty, almost_full}, exp_flags());
      end
    end
  endtask

  task automatic test_gating();
    logic [31:0] d;
    fill_to(DEPTH);
    step(1'b1, 1'b0, 32'hDEAD_BEEF);
    vectors++;
    if ({rempty, wfull, almost_empty, almost_full} !== exp_flags() || rdata !== model_q[0]) begin
      miscompares++;
      $display("FAIL full_gate: flags %b data %h expected %b data %h", {rempty, wfull, almost_empty, almost_full}, rdata, exp_flags(), model_q[0]);
    end
    while (model_q.size() > 0) begin
      vectors++;
      if (rdata !== model_q[0]) begin
        miscompares++;
        $display("FAIL full_gate_drain: got %h expected %h", rdata, model_q[0]);
      end
      step(1'b0, 1'b1, 32'd0);
    end
    step(1'b0, 1'b1, 32'd0);
    vectors++;
    if ({rempty, wfull, almost_empty, almost_full} !== exp_flags()) begin
      miscompares++;
      $display("FAIL empty_gate_flags: got %b expected %b", {rempty, wfull, almost_empty, almost_full}, exp_flags());
    end
    d = $urandom;
    step(1'b1, 1'b0, d);
    vectors++;
    if (rempty !== 1'b0 || rdata !== d) begin
      miscompares++;
      $display("FAIL empty_gate_write: rempty %b data %h expected 0 data %h", rempty, rdata, d);
    end
`ifdef DUAL_PORT_FIFO_ERR_EN
    vectors++;
    if ({overflow, underflow} !== {exp_ovf, exp_unf}) begin
      miscompares++;
      $display("FAIL err_flags: got %b expected %b", {overflow, underflow}, {exp_ovf, exp_unf});
    end
`endif
  endtask

  task automatic test_simultaneous();
    logic [31:0] head;
    fill_to(DEPTH);
    head = model_q[1];
    step(1'b1, 1'b1, $urandom);
    vectors++;
    if ({rempty, wfull, almost_empty, almost_full} !== 4'b0001 || rdata !== head) begin
      miscompares++;
      $display("FAIL sim_full: flags %b data %h expected 0001 data %h", {rempty, wfull, almost_empty, almost_full}, rdata, head);
    end
    drain_to(0);
    step(1'b1, 1'b1, 32'h1234_5678);
    vectors++;
    if (rempty !== 1'b0 || rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL sim_empty: rempty %b data %h expected 0 data 12345678", rempty, rdata);
    end
    fill_to(DEPTH / 2);
    head = model_q[1];
    step(1'b1, 1'b1, $urandom);
    vectors++;
    if ({rempty, wfull, almost_empty, almost_full} !== 4'b0000 || rdata !== head || model_q.size() != DEPTH / 2) begin
      miscompares++;
      $display("FAIL sim_half: flags %b data %h expected 0000 data %h", {rempty, wfull, almost_empty, almost_full}, rdata, head);
    end
  endtask

  task automatic test_wrap();
    drain_to(3);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, $urandom);
      vectors++;
      if ({rempty, wfull, almost_empty, almost_full} !== 4'b0000 || rdata !== model_q[0]) begin
        miscompares++;
        $display("FAIL wrap pair %0d: flags %b data %h expected 0000 data %h", i, {rempty, wfull, almost_empty, almost_full}, rdata, model_q[0]);
      end
    end
  endtask

  task automatic test_random();
    int wp;
    for (int i = 0; i < 400; i++) begin
      wp = (i / 50) % 2 == 0 ? 75 : 25;
      step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) >= wp), $urandom);
      vectors++;
      if ({rempty, wfull, almost_empty, almost_full} !== exp_flags()) begin
        miscompares++;
        $display("FAIL random_flags %0d: got %b expected %b", i, {rempty, wfull, almost_empty, almost_full}, exp_flags());
      end
      if (model_q.size() != 0) begin
        vectors++;
        if (rdata !== model_q[0]) begin
          miscompares++;
          $display("FAIL random_data %0d: got %h expected %h", i, rdata, model_q[0]);
        end
      end
`ifdef DUAL_PORT_FIFO_ERR_EN
      vectors++;
      if ({overflow, underflow} !== {exp_ovf, exp_unf}) begin
        miscompares++;
        $display("FAIL random_err %0d: got %b expected %b", i, {overflow, underflow}, {exp_ovf, exp_unf});
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    audio_word_t s;
    if (model_q.size() < 7) fill_to(7);
    else drain_to(7);
    #2;
    resetn = 1'b0;
    model_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    vectors++;
    if ({rempty, wfull, almost_empty, almost_full} !== 4'b1010) begin
      miscompares++;
      $display("FAIL async_reset_flags: got %b expected 1010", {rempty, wfull, almost_empty, almost_full});
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    resetn = 1'b1;
    s.left  = 16'($urandom);
    s.right = 16'($urandom);
    step(1'b1, 1'b0, s);
    vectors++;
    if ({rempty, wfull, almost_empty, almost_full} !== 4'b0010 || rdata !== s) begin
      miscompares++;
      $display("FAIL post_reset_write: flags %b data %h expected 0010 data %h", {rempty, wfull, almost_empty, almost_full}, rdata, s);
    end
`ifdef DUAL_PORT_FIFO_ERR_EN
    vectors++;
    if ({overflow, underflow} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_err: got %b expected 00", {overflow, underflow});
    end
`endif
  endtask

  initial begin
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    test_reset();
    test_fill_drain();
    test_gating();
    test_simultaneous();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
